tracker_occupancy_mon: RTL and testbench
========================================

TRACKER_OCCUPANCY_MON -- requirements
Module: tracker_occupancy_mon

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of tracker channels (e.g. OTT, STT).
REQ-002 SHALL have parameter ENTRIES, default 128: entries per channel; narrower channels tie unused bits to 0.
REQ-003 SHALL have parameter DEBOUNCE, default 4: consecutive cycles at/above high threshold before alarm, legal 1..255.
REQ-004 SHALL have parameter CNT_W, default 16: width of per-channel full-cycle counter.
REQ-005 SHALL derive OCC_W = clog2(ENTRIES+1).
REQ-006 SHALL have port clk  in  1  sole clock; all state rising-edge.
REQ-007 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-008 SHALL have port validvec  in  N_CH*ENTRIES  entry valid bits; channel c at [c*ENTRIES +: ENTRIES].
REQ-009 SHALL have port hi_thresh  in  N_CH*OCC_W  per-channel alarm-entry threshold.
REQ-010 SHALL have port lo_thresh  in  N_CH*OCC_W  per-channel alarm-exit threshold.
REQ-011 SHALL have port clear  in  1  synchronous clear of statistics and alarms.
REQ-012 SHALL have port occ  out  N_CH*OCC_W  registered occupancy per channel.
REQ-013 SHALL have port peak  out  N_CH*OCC_W  high-water mark per channel.
REQ-014 SHALL have port full_cycles  out  N_CH*CNT_W  saturating count of cycles with occ == ENTRIES.
REQ-015 SHALL have port alarm  out  N_CH  per-channel alarm; alarm_any  out  1  OR of alarm.

Function
REQ-016 occ[c] SHALL equal popcount of channel c validvec sampled one edge earlier (latency 1).
REQ-017 peak[c] SHALL update to max(peak[c], occ[c]) each edge, visible one cycle after occ.
REQ-018 full_cycles[c] SHALL increment by 1 on each edge where occ[c] == ENTRIES, holding at 2^CNT_W-1.
REQ-019 Each channel SHALL run FSM IDLE/PEND/ALARM on occ[c]; alarm[c] = (state == ALARM), registered.
REQ-020 IDLE->PEND when occ >= hi_thresh; debounce counter loads 1.
REQ-021 PEND->IDLE when occ < hi_thresh; PEND counter increments otherwise; PEND->ALARM on edge where counter == DEBOUNCE and occ >= hi_thresh.
REQ-022 DEBOUNCE == 1 SHALL go IDLE->ALARM directly, bypassing PEND.
REQ-023 ALARM->IDLE when occ <= lo_thresh; otherwise hold ALARM regardless of hi_thresh.
REQ-024 lo_thresh >= hi_thresh is legal; FSM follows REQ-020..023 literally (may oscillate); no check.
REQ-025 hi_thresh == 0 SHALL drive channel out of IDLE unconditionally; hi_thresh > ENTRIES SHALL never alarm.
REQ-026 clear SHALL, on its edge: peak <= occ (current), full_cycles <= 0, FSM <= IDLE, debounce <= 0; clear wins over same-cycle increment/transition.
REQ-027 occ SHALL keep updating during clear; alarm_any SHALL be a registered-input combinational OR (same cycle as alarm).
REQ-028 Thresholds SHALL be sampled combinationally each cycle; mid-PEND change takes effect next edge.

Reset
REQ-029 On resetn low: occ=0, peak=0, full_cycles=0, FSM=IDLE, debounce=0, alarm=0, alarm_any=0, asynchronously.
REQ-030 Reset assertion mid-ALARM or mid-PEND SHALL abandon state; first post-release edge samples validvec normally.

Structure
REQ-031 Package tracker_occupancy_mon_pkg SHALL hold the FSM state enum (IDLE, PEND, ALARM) and a clog2-based width function.
REQ-032 Per-channel logic SHALL be sub-module tracker_occ_chan, generate-instantiated N_CH times; top holds only slicing and alarm_any.
REQ-033 Popcount SHALL be a combinational adder tree within tracker_occ_chan; no multicycle paths.

Verification (N_CH=2, ENTRIES=8, DEBOUNCE=4, CNT_W=4, hi=6, lo=2 unless stated)
REQ-034 ch0 validvec=8'hFF from cycle 0 -> occ0=8 at cycle 1, peak0=8 at cycle 2, full_cycles0 saturates at 15 and holds.
REQ-035 ch0 occ=6 for 3 cycles then 5 -> alarm0 stays 0; occ=6 held 4 cycles -> alarm0=1, alarm_any=1.
REQ-036 In ALARM, occ drops to 3 -> alarm0 stays 1; occ drops to 2 -> alarm0=0 next edge.
REQ-037 clear pulsed same cycle as occ0==8 with full_cycles0=5 -> full_cycles0=0, peak0=8, alarm0=0 next cycle.
REQ-038 ch1 in ALARM, ch0 idle; resetn low mid-cycle -> all outputs 0 immediately; ch0 independence: ch1 occ=8 never sets alarm0.
REQ-039 DEBOUNCE=1, hi=0 -> alarm0=1 on first edge after reset release with validvec=0.

Source files
------------

// File: rtl/tracker_occupancy_mon_pkg.sv
// Shared types and helpers for the tracker occupancy monitor.
// Channel FSM states and occupancy width derivation.
package tracker_occupancy_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ALARM
  } trk_state_e;

  function automatic int occ_width(input int entries);
    return $clog2(entries + 1);
  endfunction

endpackage

// File: rtl/tracker_occ_chan.sv
// One tracker channel: popcount, high-water mark,
// saturating full counter and debounced alarm FSM.
module tracker_occ_chan
  import tracker_occupancy_mon_pkg::*;
#(
  parameter int ENTRIES  = 128,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 16,
  localparam int OCC_W   = occ_width(ENTRIES)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [ENTRIES-1:0] valid_i,
  input  logic [OCC_W-1:0]   hi_i,
  input  logic [OCC_W-1:0]   lo_i,
  input  logic               clear_i,
  output logic [OCC_W-1:0]   occ_o,
  output logic [OCC_W-1:0]   peak_o,
  output logic [CNT_W-1:0]   full_o,
  output logic               alarm_o
);

  localparam int P = 1 << $clog2(ENTRIES);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(ENTRIES);
  localparam logic [7:0] DB = 8'(DEBOUNCE);

  // Heap-ordered balanced tree: leaves at P.., root at 1.
  function automatic logic [OCC_W-1:0] popcount(
    input logic [ENTRIES-1:0] v
  );
    logic [OCC_W-1:0] node [2*P];
    for (int i = 0; i < 2*P; i++) node[i] = '0;
    for (int i = 0; i < ENTRIES; i++)
      node[P+i] = OCC_W'(v[i]);
    for (int i = P-1; i >= 1; i--)
      node[i] = node[2*i] + node[2*i+1];
    return node[1];
  endfunction

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] peak_q;
  logic [CNT_W-1:0] full_q;
  logic [7:0]       dbc_q;
  trk_state_e       state_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ_q   <= '0;
      peak_q  <= '0;
      full_q  <= '0;
      dbc_q   <= '0;
      state_q <= IDLE;
    end else begin
      occ_q <= popcount(valid_i);
      if (clear_i) begin
        peak_q  <= occ_q;
        full_q  <= '0;
        dbc_q   <= '0;
        state_q <= IDLE;
      end else begin
        if (occ_q > peak_q)
          peak_q <= occ_q;
        if (occ_q == FULL && full_q != '1)
          full_q <= full_q + CNT_W'(1);
        case (state_q)
          IDLE: if (occ_q >= hi_i) begin
            state_q <= (DEBOUNCE == 1) ? ALARM : PEND;
            dbc_q   <= 8'd1;
          end
          PEND: if (occ_q < hi_i) begin
            state_q <= IDLE;
            dbc_q   <= '0;
          end else if (dbc_q == DB) begin
            state_q <= ALARM;
          end else begin
            dbc_q <= dbc_q + 8'd1;
          end
          ALARM: if (occ_q <= lo_i) begin
            state_q <= IDLE;
            dbc_q   <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign occ_o   = occ_q;
  assign peak_o  = peak_q;
  assign full_o  = full_q;
  assign alarm_o = (state_q == ALARM);

endmodule

// File: rtl/tracker_occupancy_mon.sv
// Tracker occupancy monitor top: slices the flat buses
// into per-channel monitors and ORs their alarms.
module tracker_occupancy_mon
  import tracker_occupancy_mon_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int ENTRIES  = 128,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 16,
  localparam int OCC_W   = occ_width(ENTRIES)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_CH*ENTRIES-1:0] validvec,
  input  logic [N_CH*OCC_W-1:0]   hi_thresh,
  input  logic [N_CH*OCC_W-1:0]   lo_thresh,
  input  logic                    clear,
  output logic [N_CH*OCC_W-1:0]   occ,
  output logic [N_CH*OCC_W-1:0]   peak,
  output logic [N_CH*CNT_W-1:0]   full_cycles,
  output logic [N_CH-1:0]         alarm,
  output logic                    alarm_any
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    tracker_occ_chan #(
      .ENTRIES (ENTRIES),
      .DEBOUNCE(DEBOUNCE),
      .CNT_W   (CNT_W)
    ) u_chan (
      .clk    (clk),
      .resetn (resetn),
      .valid_i(validvec[c*ENTRIES +: ENTRIES]),
      .hi_i   (hi_thresh[c*OCC_W +: OCC_W]),
      .lo_i   (lo_thresh[c*OCC_W +: OCC_W]),
      .clear_i(clear),
      .occ_o  (occ[c*OCC_W +: OCC_W]),
      .peak_o (peak[c*OCC_W +: OCC_W]),
      .full_o (full_cycles[c*CNT_W +: CNT_W]),
      .alarm_o(alarm[c])
    );
  end

  assign alarm_any = |alarm;

endmodule

// File: tb/tb_tracker_occupancy_mon.sv
// Scoreboard bench: directed per-cycle vectors with
// hand-computed expected outputs, checked at negedge.
module tb_tracker_occupancy_mon;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] validvec = '0;
  logic [7:0]  hi_thresh = {4'd6, 4'd6};
  logic [7:0]  lo_thresh = {4'd2, 4'd2};
  logic        clear = 1'b0;
  logic [7:0]  occ, peak, full_cycles;
  logic [1:0]  alarm;
  logic        alarm_any;

  logic [15:0] d2_valid = '0;
  logic [7:0]  d2_hi = '0;
  logic [7:0]  d2_lo = '0;
  logic        d2_clear = 1'b0;
  logic [7:0]  d2_occ, d2_peak, d2_full;
  logic [1:0]  d2_alarm;
  logic        d2_any;

  always #5 clk = ~clk;

  tracker_occupancy_mon #(
    .N_CH(2), .ENTRIES(8), .DEBOUNCE(4), .CNT_W(4)
  ) dut (
    .clk(clk), .resetn(resetn), .validvec(validvec),
    .hi_thresh(hi_thresh), .lo_thresh(lo_thresh),
    .clear(clear), .occ(occ), .peak(peak),
    .full_cycles(full_cycles), .alarm(alarm),
    .alarm_any(alarm_any)
  );

  tracker_occupancy_mon #(
    .N_CH(2), .ENTRIES(8), .DEBOUNCE(1), .CNT_W(4)
  ) dut2 (
    .clk(clk), .resetn(resetn), .validvec(d2_valid),
    .hi_thresh(d2_hi), .lo_thresh(d2_lo),
    .clear(d2_clear), .occ(d2_occ), .peak(d2_peak),
    .full_cycles(d2_full), .alarm(d2_alarm),
    .alarm_any(d2_any)
  );

  typedef struct {
    logic [7:0] v0, v1;
    bit clr, rst;
    int hi1;
    int o0, p0, f0, a0, o1, p1, f1, a1;
  } vec_t;

  typedef struct {
    int k;
    vec_t v;
    int e2;
  } exp_t;

  vec_t tv[$];
  exp_t sbq[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int k,
                     input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d",
               nm, k, act, exp);
    end
  endtask

  task automatic row(input logic [7:0] v0, v1,
                     input bit clr, rst, input int hi1,
                     input int o0, p0, f0, a0,
                     input int o1, p1, f1, a1);
    vec_t t;
    t.v0 = v0; t.v1 = v1; t.clr = clr; t.rst = rst;
    t.hi1 = hi1;
    t.o0 = o0; t.p0 = p0; t.f0 = f0; t.a0 = a0;
    t.o1 = o1; t.p1 = p1; t.f1 = f1; t.a1 = a1;
    tv.push_back(t);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("occ0",  e.k, int'(occ[3:0]),         e.v.o0);
        chk("peak0", e.k, int'(peak[3:0]),        e.v.p0);
        chk("full0", e.k, int'(full_cycles[3:0]), e.v.f0);
        chk("alarm0", e.k, int'(alarm[0]),        e.v.a0);
        chk("occ1",  e.k, int'(occ[7:4]),         e.v.o1);
        chk("peak1", e.k, int'(peak[7:4]),        e.v.p1);
        chk("full1", e.k, int'(full_cycles[7:4]), e.v.f1);
        chk("alarm1", e.k, int'(alarm[1]),        e.v.a1);
        chk("alarm_any", e.k, int'(alarm_any),
            (e.v.a0 != 0 || e.v.a1 != 0) ? 1 : 0);
        chk("d2_alarm", e.k, int'(d2_alarm),
            e.e2 != 0 ? 3 : 0);
        chk("d2_any", e.k, int'(d2_any), e.e2);
        chk("d2_stats", e.k,
            int'({d2_occ, d2_peak, d2_full}), 0);
      end
    end
  end

  initial begin : driver
    exp_t e;
    // v0 v1 clr rst hi1 | o0 p0 f0 a0 | o1 p1 f1 a1
    row(8'h3F,8'h00,0,0,6, 0,0,0,0, 0,0,0,0);
    row(8'h3F,8'h00,0,0,6, 6,0,0,0, 0,0,0,0);
    row(8'h3F,8'h00,0,0,6, 6,6,0,0, 0,0,0,0);
    row(8'h1F,8'h00,0,0,6, 6,6,0,0, 0,0,0,0);
    row(8'h3F,8'h00,0,0,6, 5,6,0,0, 0,0,0,0);
    row(8'h3F,8'h00,0,0,6, 6,6,0,0, 0,0,0,0);
    row(8'h3F,8'h00,0,0,6, 6,6,0,0, 0,0,0,0);
    row(8'h3F,8'h00,0,0,6, 6,6,0,0, 0,0,0,0);
    row(8'h3F,8'h00,0,0,6, 6,6,0,0, 0,0,0,0);
    row(8'h3F,8'h00,0,0,6, 6,6,0,0, 0,0,0,0);
    row(8'h07,8'h00,0,0,6, 6,6,0,1, 0,0,0,0);
    row(8'h07,8'h00,0,0,6, 3,6,0,1, 0,0,0,0);
    row(8'h03,8'h00,0,0,6, 3,6,0,1, 0,0,0,0);
    row(8'h00,8'h00,0,0,6, 2,6,0,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 0,6,0,0, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,6,0,0, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,1,0, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,2,0, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,3,0, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,4,0, 0,0,0,0);
    row(8'hFF,8'h00,1,0,6, 8,8,5,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,0,0, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,1,0, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,2,0, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,3,0, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,4,0, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,5,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,6,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,7,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,8,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,9,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,10,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,11,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,12,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,13,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,14,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,15,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,15,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,15,1, 0,0,0,0);
    row(8'hFF,8'h00,0,0,6, 8,8,15,1, 0,0,0,0);
    row(8'h00,8'hFF,0,0,6, 8,8,15,1, 0,0,0,0);
    row(8'h00,8'hFF,0,0,6, 0,8,15,1, 8,0,0,0);
    row(8'h00,8'hFF,0,0,6, 0,8,15,0, 8,8,1,0);
    row(8'h00,8'hFF,0,0,6, 0,8,15,0, 8,8,2,0);
    row(8'h00,8'hFF,0,0,6, 0,8,15,0, 8,8,3,0);
    row(8'h00,8'hFF,0,0,6, 0,8,15,0, 8,8,4,0);
    row(8'h00,8'hFF,0,0,6, 0,8,15,0, 8,8,5,1);
    row(8'h00,8'hFF,0,0,6, 0,8,15,0, 8,8,6,1);
    row(8'h0F,8'h03,0,1,6, 0,0,0,0, 0,0,0,0);
    row(8'h0F,8'h03,0,0,6, 0,0,0,0, 0,0,0,0);
    row(8'h0F,8'hFF,0,0,15, 4,0,0,0, 2,0,0,0);
    row(8'h0F,8'hFF,0,0,15, 4,4,0,0, 8,2,0,0);
    row(8'h0F,8'hFF,0,0,15, 4,4,0,0, 8,8,1,0);
    row(8'h0F,8'hFF,0,0,15, 4,4,0,0, 8,8,2,0);
    row(8'h0F,8'hFF,0,0,15, 4,4,0,0, 8,8,3,0);
    row(8'h0F,8'hFF,0,0,15, 4,4,0,0, 8,8,4,0);
    row(8'h0F,8'hFF,0,0,15, 4,4,0,0, 8,8,5,0);
    row(8'h0F,8'hFF,0,0,15, 4,4,0,0, 8,8,6,0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_occ",   0, int'(occ), 0);
    chk("rst_peak",  0, int'(peak), 0);
    chk("rst_full",  0, int'(full_cycles), 0);
    chk("rst_alarm", 0, int'({alarm, alarm_any}), 0);
    chk("rst_d2",    0, int'({d2_alarm, d2_any}), 0);
    resetn = 1'b1;

    for (int k = 0; k < tv.size(); k++) begin
      @(posedge clk);
      #1;
      resetn    = !tv[k].rst;
      validvec  = {tv[k].v1, tv[k].v0};
      clear     = tv[k].clr;
      hi_thresh = {tv[k].hi1[3:0], 4'd6};
      // dut2 toggles IDLE<->ALARM each edge after reset
      e.k  = k;
      e.v  = tv[k];
      e.e2 = ((k < 48 || k >= 50) && (k % 2 == 0)) ? 1 : 0;
      sbq.push_back(e);
    end

    for (int i = 0; i < 20 && sbq.size() > 0; i++)
      @(negedge clk);
    #1;
    chk("drain", tv.size(), tv.size() - sbq.size(),
        tv.size());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
